// File: rtl/videogen_timing_ext_if.sv
// Video test-pattern bus: run controls in, registered pixel/sync stream out.
// The generator takes the master modport; the downstream consumer takes slave.
interface videogen_timing_ext_if #(
   parameter int COLOR_BITS = 8
);
   logic                      enable;
   logic [1:0]                mode;
   logic [3*COLOR_BITS-1:0]   solid_rgb;
   logic [COLOR_BITS-1:0]     R_out;
   logic [COLOR_BITS-1:0]     G_out;
   logic [COLOR_BITS-1:0]     B_out;
   logic                      HSYNC_out;
   logic                      VSYNC_out;
   logic                      DE_out;
   logic                      frame_start;

   modport master (
      input  enable, mode, solid_rgb,
      output R_out, G_out, B_out, HSYNC_out, VSYNC_out, DE_out, frame_start
   );

   modport slave (
      output enable, mode, solid_rgb,
      input  R_out, G_out, B_out, HSYNC_out, VSYNC_out, DE_out, frame_start
   );
endinterface

// File: rtl/videogen_timing_ext.sv
// Self-timed test-pattern generator: own H/V counters, four selectable patterns,
// all outputs registered once against the same counter state.
module videogen_timing_ext #(
   parameter int COLOR_BITS  = 8,
   parameter int H_SYNCLEN   = 62,
   parameter int H_BACKPORCH = 60,
   parameter int H_ACTIVE    = 720,
   parameter int H_TOTAL     = 858,
   parameter int V_SYNCLEN   = 6,
   parameter int V_BACKPORCH = 30,
   parameter int V_ACTIVE    = 480,
   parameter int V_TOTAL     = 525,
   parameter bit HSYNC_POL   = 1'b0,
   parameter bit VSYNC_POL   = 1'b0,
   parameter int RAMP_SHIFT  = 1,
   parameter int BAR_WIDTH   = 90,
   parameter int GRID_LOG2   = 4
) (
   input logic                  pclk,
   input logic                  reset_n,
   videogen_timing_ext_if.master vif
);
   // Widths leave room for the exclusive end-of-active bounds.
   localparam int HW = $clog2(H_TOTAL + 1);
   localparam int VW = $clog2(V_TOTAL + 1);
   localparam int BW = $clog2(BAR_WIDTH + 1);

   localparam logic [HW-1:0] H_LAST = HW'(H_TOTAL - 1);
   localparam logic [HW-1:0] H_SYNC = HW'(H_SYNCLEN);
   localparam logic [HW-1:0] H_BEG  = HW'(H_SYNCLEN + H_BACKPORCH);
   localparam logic [HW-1:0] H_PRE  = HW'(H_SYNCLEN + H_BACKPORCH - 1);
   localparam logic [HW-1:0] H_END  = HW'(H_SYNCLEN + H_BACKPORCH + H_ACTIVE);
   localparam logic [HW-1:0] X_LAST = HW'(H_ACTIVE - 1);
   localparam logic [VW-1:0] V_LAST = VW'(V_TOTAL - 1);
   localparam logic [VW-1:0] V_SYNC = VW'(V_SYNCLEN);
   localparam logic [VW-1:0] V_BEG  = VW'(V_SYNCLEN + V_BACKPORCH);
   localparam logic [VW-1:0] V_END  = VW'(V_SYNCLEN + V_BACKPORCH + V_ACTIVE);
   localparam logic [VW-1:0] Y_LAST = VW'(V_ACTIVE - 1);
   localparam logic [BW-1:0] B_LAST = BW'(BAR_WIDTH - 1);

   logic [HW-1:0]             h_cnt;
   logic [VW-1:0]             v_cnt;
   logic [1:0]                mode_r;
   logic [3*COLOR_BITS-1:0]   solid_r;
   logic [BW-1:0]             bar_cnt;
   logic [2:0]                bar_idx;

   logic                      origin, h_act, v_act, act, grid;
   logic [HW-1:0]             x;
   logic [VW-1:0]             y;
   logic [COLOR_BITS-1:0]     ramp;
   logic [3*COLOR_BITS-1:0]   px;

   always_comb begin
      origin = (h_cnt == '0) && (v_cnt == '0);
      h_act  = (h_cnt >= H_BEG) && (h_cnt < H_END);
      v_act  = (v_cnt >= V_BEG) && (v_cnt < V_END);
      act    = h_act && v_act;
      x      = h_cnt - H_BEG;
      y      = v_cnt - V_BEG;
      ramp   = COLOR_BITS'(x >> RAMP_SHIFT);
      grid   = (x[GRID_LOG2-1:0] == '0) || (y[GRID_LOG2-1:0] == '0) ||
               (x == X_LAST) || (y == Y_LAST);
      px     = '0;
      if (act) begin
         case (mode_r)
            2'd0:    px = {3{ramp}};
            // Bar order white..black maps to R=~idx[1], G=~idx[2], B=~idx[0].
            2'd1:    px = {{COLOR_BITS{~bar_idx[1]}}, {COLOR_BITS{~bar_idx[2]}},
                           {COLOR_BITS{~bar_idx[0]}}};
            2'd2:    px = solid_r;
            default: px = grid ? {3*COLOR_BITS{1'b1}} : '0;
         endcase
      end
   end

   always_ff @(posedge pclk or negedge reset_n) begin
      if (!reset_n) begin
         h_cnt           <= '0;
         v_cnt           <= '0;
         mode_r          <= '0;
         solid_r         <= '0;
         bar_cnt         <= '0;
         bar_idx         <= '0;
         vif.R_out       <= '0;
         vif.G_out       <= '0;
         vif.B_out       <= '0;
         vif.HSYNC_out   <= ~HSYNC_POL;
         vif.VSYNC_out   <= ~VSYNC_POL;
         vif.DE_out      <= 1'b0;
         vif.frame_start <= 1'b0;
      end else if (!vif.enable) begin
         h_cnt           <= '0;
         v_cnt           <= '0;
         bar_cnt         <= '0;
         bar_idx         <= '0;
         vif.R_out       <= '0;
         vif.G_out       <= '0;
         vif.B_out       <= '0;
         vif.HSYNC_out   <= ~HSYNC_POL;
         vif.VSYNC_out   <= ~VSYNC_POL;
         vif.DE_out      <= 1'b0;
         vif.frame_start <= 1'b0;
      end else begin
         if (h_cnt == H_LAST) begin
            h_cnt <= '0;
            v_cnt <= (v_cnt == V_LAST) ? '0 : v_cnt + VW'(1);
         end else begin
            h_cnt <= h_cnt + HW'(1);
         end

         // Pattern controls only move at the frame origin so a frame never tears.
         if (origin) begin
            mode_r  <= vif.mode;
            solid_r <= vif.solid_rgb;
         end

         // Bar state is cleared one pixel early so it reads 0 while x=0 is shown.
         if (h_cnt == H_PRE) begin
            bar_cnt <= '0;
            bar_idx <= '0;
         end else if (h_act) begin
            if (bar_cnt == B_LAST) begin
               bar_cnt <= '0;
               if (bar_idx != 3'd7) bar_idx <= bar_idx + 3'd1;
            end else begin
               bar_cnt <= bar_cnt + BW'(1);
            end
         end

         {vif.R_out, vif.G_out, vif.B_out} <= px;
         vif.HSYNC_out   <= (h_cnt < H_SYNC) ? HSYNC_POL : ~HSYNC_POL;
         vif.VSYNC_out   <= (v_cnt < V_SYNC) ? VSYNC_POL : ~VSYNC_POL;
         vif.DE_out      <= act;
         vif.frame_start <= origin;
      end
   end
endmodule

// File: tb/tb_videogen_timing_ext.sv
// Scoreboard bench for videogen_timing_ext on a shrunken raster (58x14) so whole
// frames run quickly; a behavioural pixel model predicts every output cycle.
`timescale 1ns/1ps
module tb_videogen_timing_ext;
   localparam int CB = 4, HS = 4, HBP = 4, HACT = 44, HT = 58;
   localparam int VS = 2, VBP = 2, VACT = 8, VT = 14;
   localparam bit HPOL = 1'b0, VPOL = 1'b1;
   localparam int RS = 1, BWID = 5, GL = 2;
   localparam int HA = HS + HBP, VA = VS + VBP, FRAME = HT * VT, MAXV = (1 << CB) - 1;

   typedef struct packed {
      logic [CB-1:0] r, g, b;
      logic          hs, vs, de, fs;
   } out_t;
   typedef struct { out_t o; int h; int v; int md; } ent_t;

   logic pclk = 1'b0;
   logic reset_n;
   always #5 pclk = ~pclk;

   videogen_timing_ext_if #(.COLOR_BITS(CB)) vif();

   videogen_timing_ext #(
      .COLOR_BITS(CB), .H_SYNCLEN(HS), .H_BACKPORCH(HBP), .H_ACTIVE(HACT), .H_TOTAL(HT),
      .V_SYNCLEN(VS), .V_BACKPORCH(VBP), .V_ACTIVE(VACT), .V_TOTAL(VT),
      .HSYNC_POL(HPOL), .VSYNC_POL(VPOL), .RAMP_SHIFT(RS), .BAR_WIDTH(BWID), .GRID_LOG2(GL)
   ) dut (
      .pclk(pclk),
      .reset_n(reset_n),
      .vif(vif)
   );

   int checks = 0, fails = 0, cyc = 0;
   int m_h = 0, m_v = 0, m_md = 0;
   logic [3*CB-1:0] m_solid = '0;
   ent_t sb[$];
   ent_t cur;
   out_t act;

   function automatic out_t rst_o();
      out_t o;
      o = '0;
      o.hs = ~HPOL;
      o.vs = ~VPOL;
      return o;
   endfunction

   function automatic out_t model_px(int h, int v, int md, logic [3*CB-1:0] s);
      out_t o;
      int x, y, idx;
      logic [2:0] bar;
      o = '0;
      o.hs = (h < HS) ? HPOL : ~HPOL;
      o.vs = (v < VS) ? VPOL : ~VPOL;
      o.fs = (h == 0 && v == 0);
      if (h >= HA && h < HA + HACT && v >= VA && v < VA + VACT) begin
         x = h - HA;
         y = v - VA;
         o.de = 1'b1;
         case (md)
            0: begin
               o.r = CB'((x >> RS) % (MAXV + 1));
               o.g = o.r;
               o.b = o.r;
            end
            1: begin
               idx = x / BWID;
               if (idx > 7) idx = 7;
               case (idx)
                  0: bar = 3'b111;  1: bar = 3'b110;  2: bar = 3'b011;  3: bar = 3'b010;
                  4: bar = 3'b101;  5: bar = 3'b100;  6: bar = 3'b001;  default: bar = 3'b000;
               endcase
               o.r = bar[2] ? CB'(MAXV) : '0;
               o.g = bar[1] ? CB'(MAXV) : '0;
               o.b = bar[0] ? CB'(MAXV) : '0;
            end
            2: {o.r, o.g, o.b} = s;
            default:
               if ((x % (1 << GL)) == 0 || (y % (1 << GL)) == 0 || x == HACT - 1 || y == VACT - 1)
                  {o.r, o.g, o.b} = {3*CB{1'b1}};
         endcase
      end
      return o;
   endfunction

   // Predict this edge's output, advance the model, then pop and compare after the edge.
   task automatic tick();
      ent_t e;
      if (!reset_n || !vif.enable) begin
         e.o = rst_o(); e.h = -1; e.v = -1; e.md = m_md;
         m_h = 0; m_v = 0;
         if (!reset_n) begin m_md = 0; m_solid = '0; end
      end else begin
         e.o = model_px(m_h, m_v, m_md, m_solid); e.h = m_h; e.v = m_v; e.md = m_md;
         if (m_h == 0 && m_v == 0) begin m_md = int'(vif.mode); m_solid = vif.solid_rgb; end
         m_h++;
         if (m_h == HT) begin m_h = 0; m_v++; if (m_v == VT) m_v = 0; end
      end
      sb.push_back(e);
      @(posedge pclk); #2; cyc++;
      act = {vif.R_out, vif.G_out, vif.B_out, vif.HSYNC_out, vif.VSYNC_out, vif.DE_out, vif.frame_start};
      cur = sb.pop_front();
      checks++;
      if (act !== cur.o) begin
         fails++;
         $display("FAIL scoreboard h=%0d v=%0d md=%0d got=%h exp=%h", cur.h, cur.v, cur.md, act, cur.o);
      end
   endtask

   task automatic goto(input int h, input int v);
      int n = 0;
      while (!(m_h == h && m_v == v) && n < 2 * FRAME) begin tick(); n++; end
      if (!(m_h == h && m_v == v)) begin
         checks++; fails++;
         $display("FAIL goto_timeout at h=%0d v=%0d wanted h=%0d v=%0d", m_h, m_v, h, v);
      end
   endtask

   task automatic test_reset();
      reset_n = 1'b0;
      vif.enable = 1'b1; vif.mode = 2'd0; vif.solid_rgb = '0;
      repeat (3) begin
         tick();
         checks++;
         if (act !== rst_o()) begin fails++; $display("FAIL reset_state got=%h exp=%h", act, rst_o()); end
      end
   endtask

   task automatic test_timing();
      int fs_t[$];
      int rel, de_cnt = 0, hs_cnt = 0, de_line = 0, first = -1, last = -1;
      reset_n = 1'b1;
      rel = cyc;
      for (int i = 0; i < 2 * FRAME + 1; i++) begin
         tick();
         if (act.fs) fs_t.push_back(cyc);
         if (fs_t.size() == 1) begin
            if (act.de) begin
               de_cnt++;
               if (first < 0) first = cur.v;
               last = cur.v;
            end
            if (cur.v == VA + 1 && act.hs == HPOL) hs_cnt++;
            if (cur.v == VA + 1 && act.de) de_line++;
         end
      end
      checks++;
      if (fs_t.size() != 3) begin
         fails++; $display("FAIL fs_count got=%0d exp=3", fs_t.size());
      end else begin
         checks += 2;
         if (fs_t[0] != rel + 1) begin fails++; $display("FAIL fs_first got=%0d exp=%0d", fs_t[0], rel + 1); end
         if (fs_t[1] - fs_t[0] != FRAME) begin fails++; $display("FAIL fs_period got=%0d exp=%0d", fs_t[1] - fs_t[0], FRAME); end
      end
      checks += 5;
      if (de_cnt != HACT * VACT) begin fails++; $display("FAIL de_per_frame got=%0d exp=%0d", de_cnt, HACT * VACT); end
      if (hs_cnt != HS) begin fails++; $display("FAIL hsync_width got=%0d exp=%0d", hs_cnt, HS); end
      if (de_line != HACT) begin fails++; $display("FAIL de_per_line got=%0d exp=%0d", de_line, HACT); end
      if (first != VA) begin fails++; $display("FAIL de_first_line got=%0d exp=%0d", first, VA); end
      if (last != VA + VACT - 1) begin fails++; $display("FAIL de_last_line got=%0d exp=%0d", last, VA + VACT - 1); end
   endtask

   task automatic test_ramp();
      int ex;
      repeat (FRAME) begin
         tick();
         if (cur.md == 0 && cur.v == VA + 2 && cur.h >= HA && cur.h < HA + HACT) begin
            case (cur.h - HA)
               0: ex = 0;  31: ex = 15;  32: ex = 0;  43: ex = 5;  default: ex = -1;
            endcase
            if (ex >= 0) begin
               checks++;
               if (act.r !== CB'(ex) || act.g !== act.r || act.b !== act.r) begin
                  fails++; $display("FAIL ramp x=%0d got=%h%h%h exp=%0h", cur.h - HA, act.r, act.g, act.b, ex);
               end
            end
         end
      end
   endtask

   task automatic test_bars();
      logic [3*CB-1:0] ex;
      logic chk;
      vif.mode = 2'd1;
      goto(0, 0);
      repeat (FRAME) begin
         tick();
         chk = 1'b1;
         case (cur.h - HA)
            -1: ex = 12'h000;  0: ex = 12'hFFF;  4: ex = 12'hFFF;  5: ex = 12'hFF0;
            10: ex = 12'h0FF;  15: ex = 12'h0F0;  34: ex = 12'h00F;  35: ex = 12'h000;
            43: ex = 12'h000;  default: chk = 1'b0;
         endcase
         if (cur.md == 1 && cur.v == VA + 3 && chk) begin
            checks++;
            if ({act.r, act.g, act.b} !== ex) begin
               fails++; $display("FAIL bars x=%0d got=%h exp=%h", cur.h - HA, {act.r, act.g, act.b}, ex);
            end
         end
      end
   endtask

   task automatic test_switch();
      int n = 0, torn = 0, solid = 0;
      vif.mode = 2'd0;
      goto(0, 0);
      tick();
      goto(0, VA + 3);
      vif.mode = 2'd2; vif.solid_rgb = 12'h123;
      while (!(m_h == 0 && m_v == 0) && n < 2 * FRAME) begin
         tick(); n++;
         if (act.de && !(act.r == act.g && act.g == act.b)) torn++;
         if (cur.v == VA + 5 && cur.h == HA + 10) begin
            checks++;
            if ({act.r, act.g, act.b} !== 12'h555) begin
               fails++; $display("FAIL switch_same_frame got=%h exp=555", {act.r, act.g, act.b});
            end
         end
      end
      checks++;
      if (torn != 0) begin fails++; $display("FAIL switch_tear got=%0d exp=0", torn); end
      repeat (FRAME) begin
         tick();
         if (act.de && {act.r, act.g, act.b} == 12'h123) solid++;
      end
      checks++;
      if (solid != HACT * VACT) begin fails++; $display("FAIL switch_next_frame got=%0d exp=%0d", solid, HACT * VACT); end
   endtask

   task automatic test_grid();
      int w0 = 0, w7 = 0;
      logic [3*CB-1:0] ex;
      logic chk;
      vif.mode = 2'd3;
      goto(0, 0);
      repeat (FRAME) begin
         tick();
         if (cur.md == 3 && act.de && {act.r, act.g, act.b} == 12'hFFF) begin
            if (cur.v == VA) w0++;
            if (cur.v == VA + VACT - 1) w7++;
         end
         chk = 1'b1;
         case (cur.h - HA)
            0, 4, 43: ex = 12'hFFF;  1, 3: ex = 12'h000;  default: chk = 1'b0;
         endcase
         if (cur.md == 3 && cur.v == VA + 1 && chk) begin
            checks++;
            if ({act.r, act.g, act.b} !== ex) begin
               fails++; $display("FAIL grid_row1 x=%0d got=%h exp=%h", cur.h - HA, {act.r, act.g, act.b}, ex);
            end
         end
      end
      checks += 2;
      if (w0 != HACT) begin fails++; $display("FAIL grid_row0 got=%0d exp=%0d", w0, HACT); end
      if (w7 != HACT) begin fails++; $display("FAIL grid_last_row got=%0d exp=%0d", w7, HACT); end
   endtask

   task automatic test_midreset();
      int rel, f1 = -1, f2 = -1;
      out_t now;
      vif.mode = 2'd0;
      goto(0, 0);
      goto(HA + 20, VA + 4);
      reset_n = 1'b0;
      #1;
      now = {vif.R_out, vif.G_out, vif.B_out, vif.HSYNC_out, vif.VSYNC_out, vif.DE_out, vif.frame_start};
      checks++;
      if (now !== rst_o()) begin fails++; $display("FAIL async_reset got=%h exp=%h", now, rst_o()); end
      repeat (2) tick();
      reset_n = 1'b1;
      rel = cyc;
      repeat (FRAME + 1) begin
         tick();
         if (act.fs) begin
            if (f1 < 0) f1 = cyc;
            else if (f2 < 0) f2 = cyc;
         end
      end
      checks += 2;
      if (f1 != rel + 1) begin fails++; $display("FAIL restart_fs got=%0d exp=%0d", f1, rel + 1); end
      if (f2 - f1 != FRAME) begin fails++; $display("FAIL restart_period got=%0d exp=%0d", f2 - f1, FRAME); end
      vif.enable = 1'b0;
      repeat (4) begin
         tick();
         checks++;
         if (act !== rst_o()) begin fails++; $display("FAIL enable_hold got=%h exp=%h", act, rst_o()); end
      end
      vif.enable = 1'b1;
      tick();
      checks++;
      if (act.fs !== 1'b1) begin fails++; $display("FAIL enable_fs got=%b exp=1", act.fs); end
   endtask

   initial begin
      test_reset();
      test_timing();
      test_ramp();
      test_bars();
      test_switch();
      test_grid();
      test_midreset();
      $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
      $finish;
   end
endmodule
